// File: rtl/burst_sync_pkg.sv
// Shared types and constants for the burst detector sequencer: FSM states,
// result record type codes and result word field positions.
package burst_sync_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        REPORT  = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    localparam logic [1:0] RES_BURST   = 2'b01;
    localparam logic [1:0] RES_TIMEOUT = 2'b10;

    localparam int RES_TYPE_MSB  = 63;
    localparam int RES_TYPE_LSB  = 62;
    localparam int RES_OVR_BIT   = 61;
    localparam int RES_PHASE_MSB = 47;
    localparam int RES_PHASE_LSB = 32;

    // Width of a counter that must reach n-1; at least one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/burst_sync_beat_cnt.sv
// Beat counter with synchronous zero-load and a terminal-count flag that is
// high while the count equals TC.
module burst_sync_beat_cnt #(
    parameter int W  = 8,
    parameter int TC = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic at_tc
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_tc = (cnt_q == W'(TC));

endmodule

// File: rtl/burst_sync_ctrl.sv
// Burst detector sequencer: arm/clear, beat indexing, holdoff, search timeout
// and one result record per event. Define BURST_SYNC_STATS_EN for record counters.
//
// state   | meaning
// IDLE    | detector beats discarded, waiting for arm
// ARMED   | searching for a burst flag, timeout running
// REPORT  | result record offered on res_*, waiting for handshake
// HOLDOFF | ignoring beats after a reported burst before re-arming
module burst_sync_ctrl
    import burst_sync_pkg::*;
#(
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int HOLDOFF_LEN    = 256,
    parameter int IDX_W          = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        arm,
    input  logic        disarm,
    input  logic        continuous,
    output logic        det_clear,
    input  logic [15:0] det_tdata,
    input  logic        det_tlast,
    input  logic        det_tvalid,
    output logic        det_tready,
    output logic [63:0] res_tdata,
    output logic        res_tvalid,
    input  logic        res_tready,
    output logic        busy
`ifdef BURST_SYNC_STATS_EN
    ,
    output logic [15:0] stat_bursts,
    output logic [15:0] stat_timeouts
`endif
);

    localparam int SEARCH_W  = cnt_width(SEARCH_TIMEOUT);
    localparam int HOLD_W    = cnt_width(HOLDOFF_LEN);
    localparam int SEARCH_TC = (SEARCH_TIMEOUT > 0) ? SEARCH_TIMEOUT - 1 : 0;
    localparam int HOLD_TC   = (HOLDOFF_LEN > 0) ? HOLDOFF_LEN - 1 : 0;
    localparam logic TIMEOUT_EN = (SEARCH_TIMEOUT != 0);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mode_q, mode_d;
    logic               overrun_q, overrun_d;
    logic               disarm_seen_q, disarm_seen_d;
    logic               res_valid_q, res_valid_d;
    logic [63:0]        res_data_q, res_data_d;
    logic               det_clear_q, det_clear_d;
    logic               search_clr, search_inc, search_tc;
    logic               hold_clr, hold_inc, hold_tc;
    logic               beat;

    function automatic logic [63:0] pack_rec(input logic [1:0] typ, input logic ovr,
                                             input logic [15:0] phase,
                                             input logic [IDX_W-1:0] index);
        logic [63:0] r;
        r = '0;
        r[RES_TYPE_MSB:RES_TYPE_LSB]   = typ;
        r[RES_OVR_BIT]                 = ovr;
        r[RES_PHASE_MSB:RES_PHASE_LSB] = phase;
        r[IDX_W-1:0]                   = index;
        return r;
    endfunction

    assign beat = det_tvalid;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mode_d        = mode_q;
        overrun_d     = overrun_q;
        disarm_seen_d = disarm_seen_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        det_clear_d   = 1'b0;
        search_clr    = 1'b0;
        search_inc    = 1'b0;
        hold_clr      = 1'b0;
        hold_inc      = 1'b0;

        if (clear) begin
            state_d       = IDLE;
            idx_d         = '0;
            mode_d        = 1'b0;
            overrun_d     = 1'b0;
            disarm_seen_d = 1'b0;
            res_valid_d   = 1'b0;
            res_data_d    = '0;
            search_clr    = 1'b1;
            hold_clr      = 1'b1;
        end else begin
            if (state_q != IDLE && beat) begin
                idx_d = idx_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (arm && !disarm) begin
                        state_d     = ARMED;
                        det_clear_d = 1'b1;
                        idx_d       = '0;
                        overrun_d   = 1'b0;
                        mode_d      = continuous;
                        search_clr  = 1'b1;
                    end
                end
                ARMED: begin
                    search_inc = beat;
                    // A burst flag on the timeout beat takes precedence.
                    if (disarm) begin
                        state_d = IDLE;
                    end else if (beat && det_tlast) begin
                        state_d       = REPORT;
                        res_valid_d   = 1'b1;
                        res_data_d    = pack_rec(RES_BURST, overrun_q, det_tdata, idx_q);
                        overrun_d     = 1'b0;
                        disarm_seen_d = 1'b0;
                    end else if (TIMEOUT_EN && beat && search_tc) begin
                        state_d       = REPORT;
                        res_valid_d   = 1'b1;
                        res_data_d    = pack_rec(RES_TIMEOUT, overrun_q, 16'h0000, idx_q);
                        overrun_d     = 1'b0;
                        disarm_seen_d = 1'b0;
                    end
                end
                REPORT: begin
                    disarm_seen_d = disarm_seen_q | disarm;
                    if (beat && det_tlast) begin
                        overrun_d = 1'b1;
                    end
                    if (res_tready) begin
                        res_valid_d = 1'b0;
                        if (res_data_q[RES_TYPE_MSB:RES_TYPE_LSB] == RES_TIMEOUT ||
                            disarm_seen_q || disarm || !mode_q) begin
                            state_d = IDLE;
                        end else if (HOLDOFF_LEN == 0) begin
                            state_d     = ARMED;
                            det_clear_d = 1'b1;
                            search_clr  = 1'b1;
                        end else begin
                            state_d  = HOLDOFF;
                            hold_clr = 1'b1;
                        end
                    end
                end
                HOLDOFF: begin
                    hold_inc = beat;
                    if (disarm) begin
                        state_d = IDLE;
                    end else if (beat && hold_tc) begin
                        state_d     = ARMED;
                        det_clear_d = 1'b1;
                        search_clr  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            mode_q        <= 1'b0;
            overrun_q     <= 1'b0;
            disarm_seen_q <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            det_clear_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mode_q        <= mode_d;
            overrun_q     <= overrun_d;
            disarm_seen_q <= disarm_seen_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            det_clear_q   <= det_clear_d;
        end
    end

    burst_sync_beat_cnt #(.W(SEARCH_W), .TC(SEARCH_TC)) u_search_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (search_clr),
        .inc     (search_inc),
        .at_tc   (search_tc)
    );

    burst_sync_beat_cnt #(.W(HOLD_W), .TC(HOLD_TC)) u_hold_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (hold_clr),
        .inc     (hold_inc),
        .at_tc   (hold_tc)
    );

    assign det_clear  = det_clear_q;
    assign det_tready = 1'b1;
    assign res_tdata  = res_data_q;
    assign res_tvalid = res_valid_q;
    assign busy       = (state_q != IDLE);

`ifdef BURST_SYNC_STATS_EN
    logic [15:0] stat_bursts_q, stat_bursts_d;
    logic [15:0] stat_timeouts_q, stat_timeouts_d;

    always_comb begin
        stat_bursts_d   = stat_bursts_q;
        stat_timeouts_d = stat_timeouts_q;
        if (clear) begin
            stat_bursts_d   = '0;
            stat_timeouts_d = '0;
        end else if (res_valid_q && res_tready) begin
            if (res_data_q[RES_TYPE_MSB:RES_TYPE_LSB] == RES_BURST &&
                stat_bursts_q != 16'hFFFF) begin
                stat_bursts_d = stat_bursts_q + 1'b1;
            end
            if (res_data_q[RES_TYPE_MSB:RES_TYPE_LSB] == RES_TIMEOUT &&
                stat_timeouts_q != 16'hFFFF) begin
                stat_timeouts_d = stat_timeouts_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_bursts_q   <= '0;
            stat_timeouts_q <= '0;
        end else begin
            stat_bursts_q   <= stat_bursts_d;
            stat_timeouts_q <= stat_timeouts_d;
        end
    end

    assign stat_bursts   = stat_bursts_q;
    assign stat_timeouts = stat_timeouts_q;
`else
    // Record statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_burst_sync_ctrl.sv
// Self-checking bench for burst_sync_ctrl: directed scenarios plus a random
// run, compared every cycle against an event-level reference model.
module tb_burst_sync_ctrl;

    localparam int TO = 256;
    localparam int HL = 8;
    localparam int IW = 32;

    localparam int P_OFF   = 0;
    localparam int P_HUNT  = 1;
    localparam int P_OFFER = 2;
    localparam int P_QUIET = 3;

    logic        clk = 1'b0;
    logic        reset_n, clear, arm, disarm, continuous;
    logic        det_clear, det_tlast, det_tvalid, det_tready;
    logic [15:0] det_tdata;
    logic [63:0] res_tdata;
    logic        res_tvalid, res_tready, busy;
`ifdef BURST_SYNC_STATS_EN
    logic [15:0] stat_bursts, stat_timeouts;
`endif

    always #5 clk = ~clk;

    burst_sync_ctrl #(.SEARCH_TIMEOUT(TO), .HOLDOFF_LEN(HL), .IDX_W(IW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .arm        (arm),
        .disarm     (disarm),
        .continuous (continuous),
        .det_clear  (det_clear),
        .det_tdata  (det_tdata),
        .det_tlast  (det_tlast),
        .det_tvalid (det_tvalid),
        .det_tready (det_tready),
        .res_tdata  (res_tdata),
        .res_tvalid (res_tvalid),
        .res_tready (res_tready),
        .busy       (busy)
`ifdef BURST_SYNC_STATS_EN
        ,
        .stat_bursts   (stat_bursts),
        .stat_timeouts (stat_timeouts)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_clr    = 0;
    logic [63:0] got_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: remaining-beat budgets and an offered record.
    int          ph;
    logic [IW-1:0] m_idx;
    int          to_left, quiet_left;
    logic        m_ovr, m_cont, m_dflag, m_clr;
    logic [63:0] m_rec;
    int          m_nb, m_nt;

    function automatic logic [63:0] mk(input logic [1:0] typ, input logic ovr,
                                       input logic [15:0] phs, input logic [IW-1:0] ix);
        return {typ, ovr, 13'd0, phs, ix};
    endfunction

    task automatic model_reset();
        ph = P_OFF; m_idx = '0; to_left = 0; quiet_left = 0;
        m_ovr = 1'b0; m_cont = 1'b0; m_dflag = 1'b0; m_clr = 1'b0;
        m_rec = '0; m_nb = 0; m_nt = 0;
    endtask

    task automatic model_step();
        m_clr = 1'b0;
        if (!reset_n || clear) begin
            model_reset();
            return;
        end
        case (ph)
            P_OFF: if (arm && !disarm) begin
                ph = P_HUNT; m_idx = '0; to_left = TO; m_ovr = 1'b0;
                m_cont = continuous; m_clr = 1'b1;
            end
            P_HUNT: if (disarm) begin
                ph = P_OFF;
            end else if (det_tvalid) begin
                to_left--;
                if (det_tlast) begin
                    m_rec = mk(2'b01, m_ovr, det_tdata, m_idx);
                    m_ovr = 1'b0; m_dflag = 1'b0; ph = P_OFFER;
                end else if (to_left == 0) begin
                    m_rec = mk(2'b10, m_ovr, 16'h0000, m_idx);
                    m_ovr = 1'b0; m_dflag = 1'b0; ph = P_OFFER;
                end
                m_idx = m_idx + 1'b1;
            end
            P_OFFER: begin
                if (disarm) m_dflag = 1'b1;
                if (det_tvalid) begin
                    if (det_tlast) m_ovr = 1'b1;
                    m_idx = m_idx + 1'b1;
                end
                if (res_tready) begin
                    if (m_rec[63:62] == 2'b01) m_nb = (m_nb < 65535) ? m_nb + 1 : m_nb;
                    else                       m_nt = (m_nt < 65535) ? m_nt + 1 : m_nt;
                    if (m_rec[63:62] == 2'b10 || m_dflag || !m_cont) begin
                        ph = P_OFF;
                    end else if (HL == 0) begin
                        ph = P_HUNT; to_left = TO; m_clr = 1'b1;
                    end else begin
                        ph = P_QUIET; quiet_left = HL;
                    end
                end
            end
            default: if (disarm) begin
                ph = P_OFF;
            end else if (det_tvalid) begin
                m_idx = m_idx + 1'b1;
                quiet_left--;
                if (quiet_left == 0) begin
                    ph = P_HUNT; to_left = TO; m_clr = 1'b1;
                end
            end
        endcase
    endtask

    task automatic compare();
        check_eq("busy", 64'(busy), 64'(ph != P_OFF));
        check_eq("det_clear", 64'(det_clear), 64'(m_clr));
        check_eq("det_tready", 64'(det_tready), 64'd1);
        check_eq("res_tvalid", 64'(res_tvalid), 64'(ph == P_OFFER));
        if (ph == P_OFFER) check_eq("res_tdata", res_tdata, m_rec);
`ifdef BURST_SYNC_STATS_EN
        check_eq("stat_bursts", 64'(stat_bursts), 64'(m_nb));
        check_eq("stat_timeouts", 64'(stat_timeouts), 64'(m_nt));
`endif
    endtask

    task automatic step();
        if (res_tvalid && res_tready) got_q.push_back(res_tdata);
        @(posedge clk);
        model_step();
        #1;
        if (det_clear) n_clr++;
        compare();
    endtask

    task automatic idle_inputs();
        clear = 1'b0; arm = 1'b0; disarm = 1'b0; continuous = 1'b0;
        det_tvalid = 1'b0; det_tlast = 1'b0; det_tdata = 16'h0000; res_tready = 1'b1;
    endtask

    task automatic start_test();
        got_q.delete();
        n_clr = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_valid", 64'(res_tvalid), 64'd0);
        check_eq("rst_tdata", res_tdata, 64'd0);
        check_eq("rst_clr", 64'(det_clear), 64'd0);
        reset_n = 1'b1;
        step();

        // Single-shot burst on beat 200.
        start_test();
        arm = 1'b1; step(); arm = 1'b0;
        for (int b = 0; b <= 200; b++) begin
            det_tvalid = 1'b1;
            det_tlast  = (b == 200);
            det_tdata  = (b == 200) ? 16'h1234 : 16'($urandom);
            step();
        end
        idle_inputs();
        repeat (3) step();
        check_eq("t1_nrec", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check_eq("t1_rec", got_q[0], 64'h4000_1234_0000_00C8);
        check_eq("t1_nclr", 64'(n_clr), 64'd1);
        check_eq("t1_busy", 64'(busy), 64'd0);

        // Search timeout with no burst flag.
        start_test();
        arm = 1'b1; continuous = 1'b1; step(); arm = 1'b0;
        for (int b = 0; b < TO; b++) begin
            det_tvalid = 1'b1; det_tdata = 16'($urandom); step();
        end
        idle_inputs();
        repeat (3) step();
        check_eq("t2_nrec", 64'(got_q.size()), 64'd1);
        if (got_q.size() > 0) check_eq("t2_rec", got_q[0], 64'h8000_0000_0000_00FF);
        check_eq("t2_busy", 64'(busy), 64'd0);

        // Continuous: overrun inside REPORT, re-arm after holdoff, disarm in holdoff.
        start_test();
        arm = 1'b1; continuous = 1'b1; step(); arm = 1'b0;
        for (int b = 0; b <= 35; b++) begin
            det_tvalid = 1'b1;
            det_tlast  = (b == 10 || b == 12 || b == 30);
            det_tdata  = 16'hA000 + 16'(b);
            res_tready = !(b >= 10 && b < 14);
            step();
        end
        det_tvalid = 1'b0; det_tlast = 1'b0; disarm = 1'b1; step(); disarm = 1'b0;
        check_eq("t3_disarm_busy", 64'(busy), 64'd0);
        for (int b = 0; b < 20; b++) begin
            det_tvalid = 1'b1; det_tlast = (b % 5 == 0); step();
        end
        idle_inputs();
        step();
        check_eq("t3_nrec", 64'(got_q.size()), 64'd2);
        if (got_q.size() > 1) begin
            check_eq("t3_rec0", got_q[0], 64'h4000_A00A_0000_000A);
            check_eq("t3_rec1", got_q[1], 64'h6000_A01E_0000_001E);
        end
        check_eq("t3_nclr", 64'(n_clr), 64'd2);

        // arm and disarm together.
        start_test();
        arm = 1'b1; disarm = 1'b1; step(); arm = 1'b0; disarm = 1'b0;
        step();
        check_eq("t4_busy", 64'(busy), 64'd0);
        check_eq("t4_nclr", 64'(n_clr), 64'd0);

        // Long back-pressure with toggling beats.
        start_test();
        arm = 1'b1; continuous = 1'b1; step(); arm = 1'b0;
        for (int b = 0; b <= 5; b++) begin
            det_tvalid = 1'b1; det_tlast = (b == 5); det_tdata = 16'h0BEE; step();
        end
        res_tready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            det_tvalid = c[0];
            det_tlast  = c[0] && ($urandom_range(0, 9) == 0);
            det_tdata  = 16'($urandom);
            step();
        end
        check_eq("t5_hold", res_tdata, 64'h4000_0BEE_0000_0005);
        check_eq("t5_nrec_stall", 64'(got_q.size()), 64'd0);
        res_tready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            det_tvalid = 1'b1; det_tlast = (c == 20); det_tdata = 16'($urandom); step();
        end
        check_eq("t5_nrec", 64'(got_q.size()), 64'd2);
        idle_inputs();
        disarm = 1'b1; step(); disarm = 1'b0; step();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            arm        = ($urandom_range(0, 99) < 4);
            det_tvalid = ($urandom_range(0, 99) < 70);
            det_tlast  = det_tvalid && ($urandom_range(0, 999) < ((c < 1500) ? 30 : 3));
            det_tdata  = 16'($urandom);
            disarm     = !det_tvalid && ($urandom_range(0, 199) < 3);
            continuous = 1'($urandom_range(0, 1));
            res_tready = ($urandom_range(0, 99) < 60);
            clear      = ($urandom_range(0, 999) < 3);
            step();
        end
        idle_inputs();
        disarm = 1'b1; step(); disarm = 1'b0; step();

        // Async reset while a record is pending.
        arm = 1'b1; continuous = 1'b1; step(); arm = 1'b0;
        det_tvalid = 1'b1; det_tlast = 1'b1; det_tdata = 16'h5A5A; res_tready = 1'b0; step();
        det_tvalid = 1'b0; det_tlast = 1'b0; step();
        check_eq("t7_pending", 64'(res_tvalid), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t7_async_valid", 64'(res_tvalid), 64'd0);
        check_eq("t7_async_busy", 64'(busy), 64'd0);
        step(); step();
        reset_n = 1'b1;
        res_tready = 1'b1;
        step(); step();
        check_eq("t7_post_busy", 64'(busy), 64'd0);
`ifdef BURST_SYNC_STATS_EN
        check_eq("t7_stat_b", 64'(stat_bursts), 64'd0);
        check_eq("t7_stat_t", 64'(stat_timeouts), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
